// File: rtl/hc_down_counter_cascade_pkg.sv
// rtl/hc_down_counter_cascade_pkg.sv - shared constants for the cascaded down-counter
//
// Purpose: slice geometry and the slice values that drive the borrow
//          chain and the wrap through zero.
// Ports:   none (package).
package hc_pkg;

  localparam int         SLICE_W    = 4;
  localparam logic [3:0] SLICE_ZERO = 4'h0;
  localparam logic [3:0] SLICE_MAX  = 4'hF;

  // A slice lends a borrow upward only when it is enabled and already at zero.
  function automatic logic slice_borrow(input logic ent, input logic [SLICE_W-1:0] value);
    return ent & (value == SLICE_ZERO);
  endfunction

endpackage

// File: rtl/hc_down_counter_cascade_if.sv
// rtl/hc_down_counter_cascade_if.sv - control/data bundle of the cascaded down-counter
//
// Purpose: groups the load/enable controls, load value and counter status.
// Signals: n_ld (active-low load), enp (parallel enable), ent (trickle enable),
//          in[W-1:0] (load value), out[W-1:0] (count), bo (borrow out),
//          zero (out == 0), uf (sticky underflow).
// Modports: master drives controls and observes status; slave is the counter.
interface hc_down_counter_cascade_if #(
  parameter int NIBBLES = 4
);

  localparam int W = 4 * NIBBLES;

  logic         n_ld;
  logic         enp;
  logic         ent;
  logic [W-1:0] in;
  logic [W-1:0] out;
  logic         bo;
  logic         zero;
  logic         uf;

  modport master (
    output n_ld, enp, ent, in,
    input  out, bo, zero, uf
  );

  modport slave (
    input  n_ld, enp, ent, in,
    output out, bo, zero, uf
  );

endinterface

// File: rtl/hc_down_counter_cascade_slice.sv
// rtl/hc_down_counter_cascade_slice.sv - one 4-bit presettable down-counting slice
//
// Purpose: models a single 4-bit down-counter IC of the cascade.
// Ports:   clk (rising edge), rst (async, active high), n_ld (active-low
//          synchronous load), enp (parallel enable), ent (trickle enable),
//          in[3:0] (load value), out[3:0] (slice count), bo (borrow out,
//          combinational: ent & out == 0).
module hc_down_slice
  import hc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               n_ld,
  input  logic               enp,
  input  logic               ent,
  input  logic [SLICE_W-1:0] in,
  output logic [SLICE_W-1:0] out,
  output logic               bo
);

  logic [SLICE_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= SLICE_ZERO;
    end else if (!n_ld) begin
      cnt_q <= in;
    end else if (enp && ent) begin
      // Wrap is spelled out so the 0 -> F step is explicit in the slice.
      if (cnt_q == SLICE_ZERO) begin
        cnt_q <= SLICE_MAX;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  assign out = cnt_q;
  assign bo  = slice_borrow(ent, cnt_q);

endmodule

// File: rtl/hc_down_counter_cascade.sv
// rtl/hc_down_counter_cascade.sv - presettable down-counter built from cascaded 4-bit slices
//
// Purpose: W = 4*NIBBLES bit synchronous down-counter with ripple-borrow
//          enable chain, combinational borrow/zero and a sticky underflow flag.
// Ports:   clk (rising edge), rst (async, active high), bus (slave modport:
//          n_ld, enp, ent, in in; out, bo, zero, uf out).
module hc_down_counter_cascade
  import hc_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  hc_down_counter_cascade_if.slave  bus
);

  localparam int W = SLICE_W * NIBBLES;

  // ent_chain[i] is the trickle enable of slice i; ent_chain[NIBBLES] is the
  // borrow out of the top slice, i.e. ent & (count == 0).
  logic [NIBBLES:0] ent_chain;
  logic [W-1:0]     cnt;
  logic             uf_q;

  assign ent_chain[0] = bus.ent;

  for (genvar i = 0; i < NIBBLES; i++) begin : g_slice
    hc_down_slice u_slice (
      .clk  (clk),
      .rst  (rst),
      .n_ld (bus.n_ld),
      .enp  (bus.enp),
      .ent  (ent_chain[i]),
      .in   (bus.in[i*SLICE_W +: SLICE_W]),
      .out  (cnt[i*SLICE_W +: SLICE_W]),
      .bo   (ent_chain[i+1])
    );
  end

  // Only a real decrement out of zero counts as underflow; load clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uf_q <= 1'b0;
    end else if (!bus.n_ld) begin
      uf_q <= 1'b0;
    end else if (bus.enp && bus.ent && (cnt == '0)) begin
      uf_q <= 1'b1;
    end
  end

  assign bus.out  = cnt;
  assign bus.bo   = ent_chain[NIBBLES];
  assign bus.zero = (cnt == '0);
  assign bus.uf   = uf_q;

endmodule

// File: tb/tb_hc_down_counter_cascade.sv
// tb/tb_hc_down_counter_cascade.sv - directed and randomized scoreboard bench for hc_down_counter_cascade
module tb_hc_down_counter_cascade;

  logic clk;
  logic rst;

  hc_down_counter_cascade_if #(.NIBBLES(4)) if16 ();
  hc_down_counter_cascade_if #(.NIBBLES(1)) if1 ();
  hc_down_counter_cascade_if #(.NIBBLES(8)) if8 ();

  hc_down_counter_cascade #(.NIBBLES(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  hc_down_counter_cascade #(.NIBBLES(1)) dut1  (.clk(clk), .rst(rst), .bus(if1));
  hc_down_counter_cascade #(.NIBBLES(8)) dut8  (.clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // sig = dut*4 + kind; dut 0:16-bit 1:4-bit 2:32-bit; kind 0:out 1:uf 2:bo 3:zero
  function automatic logic [31:0] observe(input int sig);
    case (sig)
      0:  return 32'(if16.out);
      1:  return 32'(if16.uf);
      2:  return 32'(if16.bo);
      3:  return 32'(if16.zero);
      4:  return 32'(if1.out);
      5:  return 32'(if1.uf);
      6:  return 32'(if1.bo);
      7:  return 32'(if1.zero);
      8:  return 32'(if8.out);
      9:  return 32'(if8.uf);
      10: return 32'(if8.bo);
      11: return 32'(if8.zero);
      default: return 'x;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      n_cmp++;
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic c16(input string tag, input logic [15:0] o, input logic u,
                     input logic b, input logic z);
    push({tag, "_out"},  0, 32'(o));
    push({tag, "_uf"},   1, 32'(u));
    push({tag, "_bo"},   2, 32'(b));
    push({tag, "_zero"}, 3, 32'(z));
    drain();
  endtask

  task automatic d16(input logic nld, input logic p, input logic t, input logic [15:0] v);
    if16.n_ld = nld;
    if16.enp  = p;
    if16.ent  = t;
    if16.in   = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flat-width reference model state for the randomized phase.
  logic [31:0] m_out [3];
  logic        m_uf  [3];
  logic        m_ent [3];
  int          wid   [3];

  initial begin
    wid[0] = 16; wid[1] = 4; wid[2] = 32;
    rst = 1'b1;
    d16(1'b1, 1'b0, 1'b0, 16'h0);
    if1.n_ld = 1'b1; if1.enp = 1'b0; if1.ent = 1'b0; if1.in = '0;
    if8.n_ld = 1'b1; if8.enp = 1'b0; if8.ent = 1'b0; if8.in = '0;
    #1;
    c16("rst_init", 16'h0000, 1'b0, 1'b0, 1'b1);
    if16.ent = 1'b1;
    #1;
    c16("rst_bo_ent", 16'h0000, 1'b0, 1'b1, 1'b1);
    if16.ent = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Load wins over count, then three decrements.
    d16(1'b0, 1'b1, 1'b1, 16'hABCD);
    tick();
    c16("load_wins", 16'hABCD, 1'b0, 1'b0, 1'b0);
    d16(1'b1, 1'b1, 1'b1, 16'h0);
    repeat (3) tick();
    c16("count3", 16'hABCA, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a clock period.
    d16(1'b0, 1'b1, 1'b1, 16'h1234);
    tick();
    c16("ld1234", 16'h1234, 1'b0, 1'b0, 1'b0);
    d16(1'b1, 1'b1, 1'b1, 16'h0);
    #2 rst = 1'b1;
    #1;
    c16("rst_async", 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
    c16("rst_held", 16'h0000, 1'b0, 1'b1, 1'b1);
    d16(1'b1, 1'b0, 1'b1, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Borrow across slice boundaries.
    d16(1'b0, 1'b1, 1'b1, 16'h1000);
    tick();
    c16("ld1000", 16'h1000, 1'b0, 1'b0, 1'b0);
    d16(1'b1, 1'b1, 1'b1, 16'h0);
    tick();
    c16("x1000", 16'h0FFF, 1'b0, 1'b0, 1'b0);
    d16(1'b0, 1'b1, 1'b1, 16'h0100);
    tick();
    d16(1'b1, 1'b1, 1'b1, 16'h0);
    tick();
    c16("x0100", 16'h00FF, 1'b0, 1'b0, 1'b0);

    // Underflow, wrap, stickiness, clear by load.
    d16(1'b0, 1'b1, 1'b1, 16'h0002);
    tick();
    d16(1'b1, 1'b1, 1'b1, 16'h0);
    tick();
    c16("uf_e1", 16'h0001, 1'b0, 1'b0, 1'b0);
    tick();
    c16("uf_e2", 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
    c16("uf_e3", 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tick();
    c16("uf_e4", 16'hFFFE, 1'b1, 1'b0, 1'b0);
    d16(1'b0, 1'b1, 1'b1, 16'h0005);
    tick();
    c16("uf_clr", 16'h0005, 1'b0, 1'b0, 1'b0);
    d16(1'b0, 1'b1, 1'b1, 16'h0000);
    tick();
    c16("ld_zero", 16'h0000, 1'b0, 1'b1, 1'b1);

    // Enable gating and bo independence from enp / n_ld.
    d16(1'b0, 1'b0, 1'b1, 16'h0010);
    tick();
    d16(1'b1, 1'b0, 1'b1, 16'h0);
    repeat (5) tick();
    c16("enp_off", 16'h0010, 1'b0, 1'b0, 1'b0);
    d16(1'b1, 1'b1, 1'b0, 16'h0);
    tick();
    c16("ent_off", 16'h0010, 1'b0, 1'b0, 1'b0);
    d16(1'b0, 1'b1, 1'b0, 16'h0);
    tick();
    c16("ent_off_z", 16'h0000, 1'b0, 1'b0, 1'b1);
    d16(1'b1, 1'b1, 1'b0, 16'h0);
    tick();
    c16("ent_off_hold", 16'h0000, 1'b0, 1'b0, 1'b1);
    d16(1'b1, 1'b0, 1'b1, 16'h0);
    #1;
    c16("bo_no_enp", 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
    c16("enp_off_z", 16'h0000, 1'b0, 1'b1, 1'b1);
    d16(1'b0, 1'b1, 1'b1, 16'h0);
    #1;
    c16("bo_nld", 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
    c16("ld_over_uf", 16'h0000, 1'b0, 1'b1, 1'b1);

    // Randomized sweep of all three widths against a flat decrement model.
    d16(1'b1, 1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      m_out[d] = '0;
      m_uf[d]  = 1'b0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        logic        nld, p, t;
        logic [31:0] v, mask;
        logic [63:0] wide;
        wide = (64'd1 << wid[d]) - 64'd1;
        mask = wide[31:0];
        nld  = ($urandom_range(0, 15) != 0);
        p    = ($urandom_range(0, 7) != 0);
        t    = ($urandom_range(0, 7) != 0);
        v    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        v    = v & mask;
        case (d)
          0: begin if16.n_ld = nld; if16.enp = p; if16.ent = t; if16.in = v[15:0]; end
          1: begin if1.n_ld  = nld; if1.enp  = p; if1.ent  = t; if1.in  = v[3:0];  end
          default: begin if8.n_ld = nld; if8.enp = p; if8.ent = t; if8.in = v; end
        endcase
        if (!nld) begin
          m_out[d] = v;
          m_uf[d]  = 1'b0;
        end else if (p && t) begin
          if (m_out[d] == '0) m_uf[d] = 1'b1;
          m_out[d] = (m_out[d] - 32'd1) & mask;
        end
        m_ent[d] = t;
        push($sformatf("sw%0d_out_c%0d", d, cyc),  d*4 + 0, m_out[d]);
        push($sformatf("sw%0d_uf_c%0d", d, cyc),   d*4 + 1, 32'(m_uf[d]));
        push($sformatf("sw%0d_bo_c%0d", d, cyc),   d*4 + 2, 32'(m_ent[d] && (m_out[d] == '0)));
        push($sformatf("sw%0d_zero_c%0d", d, cyc), d*4 + 3, 32'(m_out[d] == '0));
      end
      tick();
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
